johnson_seq_ctrl: RTL and testbench
===================================

// Module: johnson_seq_ctrl
// PURPOSE
//   Controller that sequences a WIDTH-bit Johnson (twisted-ring) counter as a multi-phase
//   timing generator. Runs a programmed number of full 2*WIDTH-state rotations on start.
//   Advances only on a step strobe. Supports an orderly stop that drains back to all-zero.
//   Detects illegal ring states, self-corrects them and flags the event.
//   Sits between control logic and the phase-decoded datapath enables.
// PARAMETERS
//   WIDTH  4  ring length in flops; sequence length is 2*WIDTH states (WIDTH >= 2)
//   CNT_W  8  width of the rounds request and of the internal round counter
//   PH_W   3  phase index width; 2**PH_W >= 2*WIDTH is required
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high reset
//   start   in   1      begin a run; sampled only in IDLE
//   stop    in   1      request an early, orderly stop; sampled only in RUN
//   step    in   1      advance the ring one state; honoured only in RUN
//   rounds  in   CNT_W  number of full rotations, latched on start; 0 is treated as 1
//   q       out  WIDTH  ring state; registered
//   phase   out  PH_W   index 0..2*WIDTH-1 decoded combinationally from q
//   busy    out  1      high in RUN and DRAIN
//   done    out  1      one-cycle pulse, high while the FSM is in DONE
//   err     out  1      sticky illegal-state flag; cleared only by reset
// BEHAVIOUR
// - Reset (async): state=IDLE, q=0, round_cnt=0, rounds_l=0, busy=0, done=0, err=0.
// - Ring step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
//   WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
// - phase = q[WIDTH-1] ? 2*WIDTH - popcount(q) : popcount(q).
// - Legal q: patterns 0..01..1 or 1..10..0, including all-0 and all-1. Anything else is illegal.
// - FSM states: IDLE, RUN, DRAIN, DONE.
//   - IDLE: q is held. On start=1: rounds_l <= (rounds==0 ? 1 : rounds), round_cnt <= 0, go to RUN.
//     busy goes high the next cycle. stop and step are ignored in IDLE.
//   - RUN: each cycle with step=1, the ring steps.
//     A step from the last state (phase 2*WIDTH-1) back to 0 is a wrap; on a wrap, round_cnt increments.
//     If a wrap makes round_cnt == rounds_l, go to DONE.
//     If stop=1 and q==0, with no step this cycle, go to DONE.
//     If stop=1 and q!=0, go to DRAIN; a step in the same cycle is still applied.
//     If stop=1 and step=1 coincide with the final wrap, go to DONE; the wrap takes priority.
//     start is ignored while busy.
//   - DRAIN: the ring steps every cycle regardless of step.
//     Go to DONE in the cycle whose step produces q==0. round_cnt is not updated.
//   - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. q==0 on entry to DONE.
// - Latency: start sampled at edge N -> busy=1 from N+1. Every step sampled high in RUN moves q at that edge.
// - Illegal-state handling: checked every cycle in every state, with priority over all other transitions.
//   On an illegal q, next cycle: q=0, state=IDLE, err=1, done=0.
//   An illegal state does not produce a done pulse.
// - Reset asserted mid-run aborts immediately to reset values; no done pulse.
// - round_cnt never wraps, because the run terminates at rounds_l <= 2**CNT_W-1.
// TESTING
// - Reset mid-RUN (q=0111): assert reset between clock edges.
//   -> q=0000, busy=0, done=0, err=0 immediately, before the next edge.
// - WIDTH=4, rounds=2, start for one cycle, then step held high.
//   -> q walks the 8-state sequence twice, phase counts 0..7 twice.
//   -> busy high for 16 cycles, done pulses once, then IDLE with q=0000.
// - rounds=0 with start, step held high.
//   -> behaves as rounds=1: 8 steps, then a single done pulse.
// - step toggling 1,0,1,0 in RUN.
//   -> q advances only on step=1 cycles; phase holds on step=0 cycles.
// - stop at q=0011 (phase 2) with step=0.
//   -> DRAIN passes 0111,1111,1110,1100,1000,0000 on consecutive cycles, then done pulses; rounds are not counted.
// - Force q=0101 in RUN.
//   -> next cycle: q=0000, state IDLE, err=1 sticky, no done pulse.
//   -> a subsequent start runs normally with err still 1.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Purpose : step-gated Johnson ring sequencer; runs N full rotations, drains to zero on stop, self-heals illegal states
// Latency : start sampled at edge N -> busy from N+1; a step sampled in RUN moves q at that same edge
// Backpr. : none; the ring advances only on step (RUN) or unconditionally while draining
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, stop, step   run request (IDLE only), orderly stop (RUN only), ring advance strobe (RUN only)
//   rounds              full rotations per run, latched on start (0 behaves as 1)
//   q, phase            registered ring state and its combinational phase index
//   busy, done, err     running/draining, one-cycle completion pulse, sticky illegal-state flag
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [CNT_W-1:0] rounds,
  output logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Last state of the rotation (1 followed by zeros); stepping from it wraps to all-zero.
  localparam logic [WIDTH-1:0] LAST_Q = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx, q_step, thermo, thermo_inc;
  logic [CNT_W-1:0] round_cnt, round_cnt_nx, round_cnt_inc;
  logic [CNT_W-1:0] rounds_l, rounds_l_nx;
  logic             err_nx, legal, wrap;
  logic [PH_W-1:0]  pop;

  always_comb begin
    q_step = {q[WIDTH-2:0], ~q[WIDTH-1]};
    // Folding a 1..10..0 pattern onto 0..01..1 lets one check cover both
    // legal halves: a low-aligned run of ones has no bit in common with itself plus one.
    thermo     = q[WIDTH-1] ? ~q : q;
    thermo_inc = thermo + WIDTH'(1);
    legal      = ((thermo & thermo_inc) == '0);
    wrap       = (q == LAST_Q);
    round_cnt_inc = round_cnt + CNT_W'(1);
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PH_W'(q[i]);
    end
    // Second half of the rotation counts down from 2*WIDTH as the ones shift out.
    phase = q[WIDTH-1] ? (PH_W'(2*WIDTH) - pop) : pop;
  end

  always_comb begin
    state_nx     = state;
    q_nx         = q;
    round_cnt_nx = round_cnt;
    rounds_l_nx  = rounds_l;
    err_nx       = err;
    if (!legal) begin
      // Corruption recovery outranks every other transition and never signals done.
      q_nx     = '0;
      state_nx = S_IDLE;
      err_nx   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rounds_l_nx  = (rounds == '0) ? CNT_W'(1) : rounds;
            round_cnt_nx = '0;
            state_nx     = S_RUN;
          end
        end
        S_RUN: begin
          if (step) begin
            q_nx = q_step;
            if (wrap) begin
              round_cnt_nx = round_cnt_inc;
            end
            // The final wrap wins over a coincident stop.
            if (wrap && (round_cnt_inc == rounds_l)) begin
              state_nx = S_DONE;
            end else if (stop) begin
              state_nx = S_DRAIN;
            end
          end else if (stop) begin
            state_nx = (q == '0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          q_nx = q_step;
          if (q_step == '0) begin
            state_nx = S_DONE;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      q         <= '0;
      round_cnt <= '0;
      rounds_l  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      q         <= q_nx;
      round_cnt <= round_cnt_nx;
      rounds_l  <= rounds_l_nx;
      err       <= err_nx;
    end
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       step;
  logic [7:0] rounds;
  logic [3:0] q;
  logic [2:0] phase;
  logic       busy;
  logic       done;
  logic       err;

  int vectors;
  int miscompares;

  logic [3:0] seq [8];
  logic [3:0] drain_seq [6];

  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8), .PH_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .step   (step),
    .rounds (rounds),
    .q      (q),
    .phase  (phase),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    vectors++;
    if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: q=%b busy=%b done=%b err=%b phase=%0d, want q=0000 busy=0 done=0 err=0 phase=0",
               q, busy, done, err, phase);
    end
  endtask

  // Start with 'rot' rotations requested, step held high; expects rot_eff*8 steps.
  task automatic run_full(input logic [7:0] rot, input int nsteps, input string name);
    int busy_cnt;
    int done_cnt;
    logic [2:0] ph_exp;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start  = 1'b1;
    rounds = rot;
    step   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || q !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s_first: busy=%b q=%b, want busy=1 q=0000", name, busy, q);
    end
    if (busy === 1'b1) busy_cnt++;
    for (int i = 1; i <= nsteps; i++) begin
      @(negedge clk);
      ph_exp = i[2:0];
      vectors++;
      if (q !== seq[i % 8] || phase !== ph_exp) begin
        miscompares++;
        $display("FAIL %s_step%0d: q=%b phase=%0d, want q=%b phase=%0d", name, i, q, phase, seq[i % 8], ph_exp);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_pulse: done=%b busy=%b, want done=1 busy=0", name, done, busy);
    end
    @(negedge clk);
    step = 1'b0;
    if (done === 1'b1) done_cnt++;
    vectors++;
    if (busy_cnt != nsteps || done_cnt != 1 || q !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_summary: busy_cycles=%0d done_pulses=%0d q=%b busy=%b, want %0d 1 0000 0",
               name, busy_cnt, done_cnt, q, busy, nsteps);
    end
  endtask

  task automatic test_rounds_two();
    run_full(8'd2, 16, "rounds2");
  endtask

  task automatic test_rounds_zero();
    run_full(8'd0, 8, "rounds0");
  endtask

  task automatic test_step_toggle();
    logic       pat [4];
    logic [3:0] exp_q [4];
    logic [2:0] exp_ph [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_q = '{4'b0001, 4'b0001, 4'b0011, 4'b0011};
    exp_ph = '{3'd1, 3'd1, 3'd2, 3'd2};
    @(negedge clk);
    start  = 1'b1;
    rounds = 8'd1;
    step   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || q !== 4'b0000) begin
      miscompares++;
      $display("FAIL toggle_start: busy=%b q=%b, want busy=1 q=0000", busy, q);
    end
    for (int k = 0; k < 4; k++) begin
      step = pat[k];
      @(negedge clk);
      vectors++;
      if (q !== exp_q[k] || phase !== exp_ph[k] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL toggle_%0d: q=%b phase=%0d busy=%b, want q=%b phase=%0d busy=1",
                 k, q, phase, busy, exp_q[k], exp_ph[k]);
      end
    end
    step = 1'b0;
  endtask

  // Continues from the toggle test with the ring parked at 0011 in RUN.
  task automatic test_stop_drain();
    step = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++;
    if (q !== 4'b0011 || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_enter: q=%b busy=%b done=%b, want q=0011 busy=1 done=0", q, busy, done);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (q !== drain_seq[k] || busy !== (k != 5) || done !== (k == 5)) begin
        miscompares++;
        $display("FAIL drain_%0d: q=%b busy=%b done=%b, want q=%b busy=%b done=%b",
                 k, q, busy, done, drain_seq[k], (k != 5), (k == 5));
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 4'b0000) begin
      miscompares++;
      $display("FAIL drain_idle: done=%b busy=%b q=%b, want 0 0 0000", done, busy, q);
    end
  endtask

  task automatic test_illegal();
    int done_cnt;
    @(negedge clk);
    start  = 1'b1;
    rounds = 8'd1;
    step   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    force dut.q = 4'b0101;
    #1;
    release dut.q;
    @(posedge clk);
    #1;
    vectors++;
    if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_recover: q=%b busy=%b done=%b err=%b, want q=0000 busy=0 done=0 err=1",
               q, busy, done, err);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_idle: done=%b err=%b busy=%b, want done=0 err=1 busy=0", done, err, busy);
    end
    // A fresh run after recovery completes normally while err stays set.
    start = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    step = 1'b0;
    vectors++;
    if (done_cnt != 1 || err !== 1'b1 || q !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_rerun: done_pulses=%0d err=%b q=%b busy=%b, want 1 1 0000 0",
               done_cnt, err, q, busy);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start  = 1'b1;
    rounds = 8'd3;
    step   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    step = 1'b0;
    vectors++;
    if (q !== 4'b0111 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_setup: q=%b busy=%b, want q=0111 busy=1", q, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: q=%b busy=%b done=%b err=%b, want q=0000 busy=0 done=0 err=0",
               q, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    drain_seq = '{4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    reset  = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    step   = 1'b0;
    rounds = 8'd0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_rounds_two();
    test_rounds_zero();
    test_step_toggle();
    test_stop_drain();
    test_illegal();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
